// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Leading-zero blanking is enabled by defining BIN2BCD_BLANK_EN.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;

  // True when every WIDTH-bit value fits in DIGITS decimal digits.
  function automatic bit params_legal(input int width, input int digits);
    longint p10;
    p10 = 1;
    for (int i = 0; i < digits; i++) p10 = p10 * 10;
    return (width > 0) && (width < 63) && ((longint'(1) << width) <= p10);
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// One BCD digit of the shift-and-add-3 correction: digits of 5 or more get +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adjusted
);

  assign adjusted = (digit >= ADD3_THRESH) ? digit + BCD_W'(3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, start/done handshake.
// Define BIN2BCD_BLANK_EN to register a leading-zero blank mask on blank_out.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_out
);

  localparam int BCD_TOT = BCD_W * DIGITS;
  localparam int SR_W    = BCD_TOT + WIDTH;
  localparam int CNT_W   = $clog2(WIDTH + 1);

  if (!params_legal(WIDTH, DIGITS)) begin : g_illegal_params
    $error("bin2bcd_seq: 2^WIDTH-1 does not fit in DIGITS BCD digits");
  end

  // Handshake: start is sampled only while busy is low (IDLE or DONE);
  // done pulses for one cycle and bcd_out is valid from that cycle on.
  state_t             state;
  logic [SR_W-1:0]    sr;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_TOT-1:0] corr_bcd;
  logic [SR_W-1:0]    shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit    (sr[WIDTH + BCD_W*g +: BCD_W]),
      .adjusted (corr_bcd[BCD_W*g +: BCD_W])
    );
  end

  assign shifted = {corr_bcd, sr[WIDTH-1:0]} << 1;

`ifdef BIN2BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  logic [DIGITS-1:0] blank_next;
  logic              hi_zero;

  // Walk from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    blank_next = '0;
    hi_zero    = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero       = hi_zero & (shifted[WIDTH + BCD_W*i +: BCD_W] == '0);
      blank_next[i] = hi_zero;
    end
  end
`else
  assign blank_out = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      sr        <= '0;
      cnt       <= '0;
`ifdef BIN2BCD_BLANK_EN
      blank_out <= BLANK_RST;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sr    <= {{BCD_TOT{1'b0}}, bin_in};
            cnt   <= CNT_W'(WIDTH);
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          sr  <= shifted;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            bcd_out <= shifted[SR_W-1:WIDTH];
`ifdef BIN2BCD_BLANK_EN
            blank_out <= blank_next;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, values, ignored start, back-to-back,
// reset abort and the blank mask in whichever build is compiled.
module tb_bin2bcd_seq;

  localparam int WIDTH  = 10;
  localparam int DIGITS = 4;

  logic                clk;
  logic                reset;
  logic                start;
  logic [WIDTH-1:0]    bin_in;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   blank_out;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [4*DIGITS-1:0] exp_q[$];

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .blank_out (blank_out)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("bcd_out", 32'(bcd_out), 32'(exp_q.pop_front()));
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 1;
    busy_cycles = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cycles++;
      tick();
      lat++;
    end
  endtask

  task automatic convert(input int value, input logic [15:0] exp_bcd,
                         output int lat, output int busy_cycles);
    exp_q.push_back(exp_bcd);
    start  = 1'b1;
    bin_in = WIDTH'(value);
    tick();
    start  = 1'b0;
    wait_done(lat, busy_cycles);
  endtask

  logic [DIGITS-1:0] blank_rst_exp, blank_7_exp, blank_305_exp, blank_0_exp;
  int lat, bcyc, d0;

  initial begin
`ifdef BIN2BCD_BLANK_EN
    blank_rst_exp = 4'b1110;
    blank_7_exp   = 4'b1110;
    blank_305_exp = 4'b1000;
    blank_0_exp   = 4'b1110;
`else
    blank_rst_exp = 4'b0000;
    blank_7_exp   = 4'b0000;
    blank_305_exp = 4'b0000;
    blank_0_exp   = 4'b0000;
`endif
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_blank", 32'(blank_out), 32'(blank_rst_exp));
    tick();

    convert(0, 16'h0000, lat, bcyc);
    check("lat_0", 32'(lat), 32'd11);
    check("busy_cycles_0", 32'(bcyc), 32'd10);
    check("done_busy_low", 32'(busy), 32'd0);
    check("blank_0", 32'(blank_out), 32'(blank_0_exp));
    tick();
    check("done_one_cycle", 32'(done), 32'd0);

    convert(1023, 16'h1023, lat, bcyc);
    check("lat_1023", 32'(lat), 32'd11);
    tick();
    convert(999, 16'h0999, lat, bcyc);
    tick();
    convert(5, 16'h0005, lat, bcyc);
    tick();
    convert(7, 16'h0007, lat, bcyc);
    check("blank_7", 32'(blank_out), 32'(blank_7_exp));
    tick();
    convert(305, 16'h0305, lat, bcyc);
    check("blank_305", 32'(blank_out), 32'(blank_305_exp));
    tick();
    check("hold_bcd", 32'(bcd_out), 32'h0305);

    // Start during SHIFT is ignored.
    d0 = done_cnt;
    exp_q.push_back(16'h0637);
    start  = 1'b1;
    bin_in = WIDTH'(637);
    tick();
    start = 1'b0;
    tick();
    tick();
    start  = 1'b1;
    bin_in = WIDTH'(12);
    tick();
    start = 1'b0;
    wait_done(lat, bcyc);
    check("lat_637", 32'(lat), 32'd8);

    // Back-to-back start in the DONE cycle.
    convert(42, 16'h0042, lat, bcyc);
    check("lat_b2b", 32'(lat), 32'd11);
    check("busy_cycles_b2b", 32'(bcyc), 32'd10);
    tick();
    check("done_pulses_637_42", 32'(done_cnt - d0), 32'd2);

    // Reset mid-conversion aborts without a done pulse.
    d0 = done_cnt;
    start  = 1'b1;
    bin_in = WIDTH'(512);
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_bcd", 32'(bcd_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_blank", 32'(blank_out), 32'(blank_rst_exp));
    repeat (15) tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    convert(88, 16'h0088, lat, bcyc);
    check("lat_88", 32'(lat), 32'd11);
    tick();

    // Reset wins over a simultaneous start.
    d0 = done_cnt;
    reset  = 1'b1;
    start  = 1'b1;
    bin_in = WIDTH'(77);
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    repeat (14) tick();
    check("rst_start_no_done", 32'(done_cnt - d0), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
